// File: rtl/seq_restoring_divider_if.sv
// Start/done handshake bundle for the sequential restoring divider.
// The master drives the request and operands; the slave returns the result and status.
interface seq_restoring_divider_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             busy;
  logic             done;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  quotient, remainder, busy, done, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output quotient, remainder, busy, done, div_by_zero
  );
endinterface

// File: rtl/seq_restoring_divider.sv
// Unsigned sequential restoring divider: one quotient bit per SHIFT+COMP pair.
// Results are registered and held until the next accepted start.
module seq_restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  seq_restoring_divider_if.slave  bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_SHIFT = 3'd2;
  localparam logic [2:0] S_COMP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  logic [2:0]       state_q,     state_d;
  logic [WIDTH:0]   a_q,         a_d;
  logic [WIDTH-1:0] q_q,         q_d;
  logic [WIDTH-1:0] m_q,         m_d;
  logic [CW-1:0]    count_q,     count_d;
  logic [WIDTH-1:0] quotient_q,  quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;
  logic             dbz_q,       dbz_d;

  logic [WIDTH:0]   diff;
  logic [2*WIDTH:0] shifted;
  logic [WIDTH:0]   comp_a;
  logic [WIDTH-1:0] comp_q;

  assign diff    = a_q - {1'b0, m_q};
  assign shifted = {a_q, q_q} << 1;

  always_comb begin
    // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latches).
    state_d     = state_q;
    a_d         = a_q;
    q_d         = q_q;
    m_d         = m_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    comp_a      = a_q;
    comp_q      = q_q;

    // A borrow out of the subtraction means the divisor did not fit: keep A (restore).
    if (!diff[WIDTH]) begin
      comp_a = diff;
    end
    comp_q[0] = ~diff[WIDTH];

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          q_d     = bus.dividend;
          m_d     = bus.divisor;
          a_d     = '0;
          count_d = CW'(WIDTH);
          dbz_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (m_q == '0) begin
          dbz_d       = 1'b1;
          quotient_d  = '1;
          remainder_d = q_q;
          state_d     = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d     = shifted[2*WIDTH:WIDTH];
        q_d     = shifted[WIDTH-1:0];
        state_d = S_COMP;
      end
      S_COMP: begin
        a_d     = comp_a;
        q_d     = comp_q;
        count_d = count_q - CW'(1);
        if (count_q == CW'(1)) begin
          quotient_d  = comp_q;
          remainder_d = comp_a[WIDTH-1:0];
          state_d     = S_DONE;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      a_q         <= '0;
      q_q         <= '0;
      m_q         <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_q         <= a_d;
      q_q         <= q_d;
      m_q         <= m_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.done        = (state_q == S_DONE);

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Self-checking bench for seq_restoring_divider: directed vectors, multi-cycle corner
// sequences and a randomized sweep against a plain-arithmetic reference model.
module tb_seq_restoring_divider;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  seq_restoring_divider_if #(.WIDTH(W)) bus ();

  seq_restoring_divider #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
    int           lat;
  } vec_t;

  vec_t vecs[7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive a request for one edge; the DUT must be in IDLE on entry.
  task automatic start_op(input logic [W-1:0] a, input logic [W-1:0] b);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    tick();
    bus.start    = 1'b0;
    check("busy_after_accept", bus.busy, 1);
  endtask

  // Counts edges after the accepting edge until done; busy must stay high throughout.
  task automatic wait_done(input string name, output int lat);
    bit busy_ok;
    lat     = -1;
    busy_ok = 1'b1;
    for (int i = 1; i <= 64; i++) begin
      tick();
      if (!bus.busy) busy_ok = 1'b0;
      if (bus.done) begin
        lat = i;
        break;
      end
    end
    check({name, "_done_seen"}, bus.done, 1);
    check({name, "_busy_held"}, busy_ok, 1);
  endtask

  task automatic finish_op(input string name, input logic [W-1:0] eq, input logic [W-1:0] er,
                           input logic ez, input int elat, input int lat);
    check({name, "_quotient"}, bus.quotient, eq);
    check({name, "_remainder"}, bus.remainder, er);
    check({name, "_dbz"}, bus.div_by_zero, ez);
    check({name, "_latency"}, lat, elat);
    tick();
    check({name, "_done_pulse"}, bus.done, 0);
    check({name, "_idle"}, bus.busy, 0);
  endtask

  task automatic run_op(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eq, input logic [W-1:0] er,
                        input logic ez, input int elat);
    int lat;
    start_op(a, b);
    wait_done(name, lat);
    finish_op(name, eq, er, ez, elat, lat);
  endtask

  initial begin
    int lat;
    bit saw_done;
    logic [W-1:0] ra, rb, mq, mr;
    logic [2*W-1:0] recon;

    vecs[0] = '{8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 17};
    vecs[1] = '{8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 17};
    vecs[2] = '{8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 17};
    vecs[3] = '{8'd5,   8'd9,   8'd0,   8'd5,  1'b0, 17};
    vecs[4] = '{8'd0,   8'd3,   8'd0,   8'd0,  1'b0, 17};
    vecs[5] = '{8'd42,  8'd0,   8'hFF,  8'd42, 1'b1, 1};
    vecs[6] = '{8'd9,   8'd2,   8'd4,   8'd1,  1'b0, 17};

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (2) tick();
    check("rst_quotient", bus.quotient, 0);
    check("rst_remainder", bus.remainder, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_dbz", bus.div_by_zero, 0);
    rst = 1'b0;
    tick();

    for (int i = 0; i < 7; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].q, vecs[i].r,
             vecs[i].z, vecs[i].lat);
    end

    // Start ignored while busy, then a held start is taken on the first IDLE edge.
    start_op(8'd200, 8'd13);
    repeat (2) tick();
    bus.start = 1'b1; bus.dividend = 8'd7; bus.divisor = 8'd7;
    tick();
    bus.start = 1'b0; bus.dividend = 8'd1; bus.divisor = 8'd1;
    repeat (2) tick();
    bus.start = 1'b1; bus.dividend = 8'd9; bus.divisor = 8'd2;
    wait_done("ignore", lat);
    check("ignore_quotient", bus.quotient, 15);
    check("ignore_remainder", bus.remainder, 5);
    check("ignore_dbz", bus.div_by_zero, 0);
    check("ignore_latency", lat, 12);
    tick();
    check("held_start_in_done_ignored", bus.busy, 0);
    tick();
    check("held_start_accepted", bus.busy, 1);
    bus.start = 1'b0;
    wait_done("held", lat);
    finish_op("held", 8'd4, 8'd1, 1'b0, 17, lat);

    // Asynchronous reset in the middle of an operation aborts it without a done.
    start_op(8'd100, 8'd7);
    repeat (4) tick();
    #2 rst = 1'b1;
    #1;
    check("abort_quotient", bus.quotient, 0);
    check("abort_remainder", bus.remainder, 0);
    check("abort_busy", bus.busy, 0);
    check("abort_done", bus.done, 0);
    check("abort_dbz", bus.div_by_zero, 0);
    repeat (2) tick();
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op("after_abort", 8'd100, 8'd7, 8'd14, 8'd2, 1'b0, 17);

    // Random sweep against plain arithmetic.
    for (int n = 0; n < 2000; n++) begin
      ra = W'($urandom);
      rb = (n % 50 == 0) ? '0 : W'($urandom);
      if (rb == 0) begin
        mq = '1;
        mr = ra;
      end else begin
        mq = ra / rb;
        mr = ra % rb;
      end
      start_op(ra, rb);
      wait_done("rand", lat);
      finish_op("rand", mq, mr, (rb == 0), (rb == 0) ? 1 : 17, lat);
      if (rb != 0) begin
        recon = bus.quotient * rb + {{W{1'b0}}, bus.remainder};
        check("rand_identity", recon, {{W{1'b0}}, ra});
        check("rand_rem_lt_div", (bus.remainder < rb), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
